// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Inter-stage pipeline register with valid, flush, bubble/hold
//            statistics and a sticky stall-timeout flag.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int                DATA_W   = 128,
    parameter logic [DATA_W-1:0] NOP_DATA = '0,
    parameter int                CNT_W    = 16,
    parameter int                TIMEOUT  = 1024
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [1:0]        STALL,
    input  logic              FLUSH,
    input  logic              IN_VALID,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              OUT_VALID,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [CNT_W-1:0]  BUBBLE_CNT,
    output logic [CNT_W-1:0]  HOLD_CNT,
    output logic              STALL_TIMEOUT
);

    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_bubble_cnt;
    logic [CNT_W-1:0]  r_hold_cnt;
    logic              r_timeout;

    logic              w_valid_nxt;
    logic [DATA_W-1:0] w_data_nxt;
    logic [CNT_W-1:0]  w_bubble_nxt;
    logic [CNT_W-1:0]  w_hold_nxt;
    logic              w_timeout_nxt;
    logic [CNT_W-1:0]  w_bubble_inc;
    logic [CNT_W-1:0]  w_hold_inc;

    assign w_bubble_inc = (&r_bubble_cnt) ? r_bubble_cnt : r_bubble_cnt + c_one;
    assign w_hold_inc   = (&r_hold_cnt)   ? r_hold_cnt   : r_hold_cnt + c_one;

    // Flush beats every stall combination; STALL=2'b10 falls into the load case.
    always_comb begin
        w_valid_nxt   = r_valid;
        w_data_nxt    = r_data;
        w_bubble_nxt  = r_bubble_cnt;
        w_hold_nxt    = r_hold_cnt;
        w_timeout_nxt = r_timeout;
        if (FLUSH) begin
            w_valid_nxt = 1'b0;
            w_data_nxt  = NOP_DATA;
            w_hold_nxt  = '0;
        end else if (!STALL[0]) begin
            w_valid_nxt = IN_VALID;
            w_data_nxt  = IN_DATA;
            w_hold_nxt  = '0;
        end else if (!STALL[1]) begin
            w_valid_nxt  = 1'b0;
            w_data_nxt   = NOP_DATA;
            w_hold_nxt   = '0;
            w_bubble_nxt = w_bubble_inc;
        end else begin
            w_hold_nxt = w_hold_inc;
            if (w_hold_inc == c_timeout) begin
                w_timeout_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_valid      <= 1'b0;
            r_data       <= NOP_DATA;
            r_bubble_cnt <= '0;
            r_hold_cnt   <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_valid      <= w_valid_nxt;
            r_data       <= w_data_nxt;
            r_bubble_cnt <= w_bubble_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_timeout    <= w_timeout_nxt;
        end
    end

    assign OUT_VALID     = r_valid;
    assign OUT_DATA      = r_data;
    assign BUBBLE_CNT    = r_bubble_cnt;
    assign HOLD_CNT      = r_hold_cnt;
    assign STALL_TIMEOUT = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Brief    : Directed self-checking bench for pipe_stage_reg.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam logic [15:0] c_nop = 16'hBEEF;

    logic        CLK = 1'b0;
    int          checks = 0;
    int          errors = 0;

    // Main instance: DATA_W=16, CNT_W=4, TIMEOUT=8
    logic        RST = 1'b0;
    logic [1:0]  STALL = 2'b00;
    logic        FLUSH = 1'b0;
    logic        IN_VALID = 1'b0;
    logic [15:0] IN_DATA = '0;
    logic        OUT_VALID;
    logic [15:0] OUT_DATA;
    logic [3:0]  BUBBLE_CNT;
    logic [3:0]  HOLD_CNT;
    logic        STALL_TIMEOUT;

    // Saturation instance: DATA_W=8, CNT_W=2
    logic        s_rst = 1'b0;
    logic [1:0]  s_stall = 2'b00;
    logic        s_flush = 1'b0;
    logic        s_in_valid = 1'b0;
    logic [7:0]  s_in_data = '0;
    logic        s_out_valid;
    logic [7:0]  s_out_data;
    logic [1:0]  s_bubble_cnt;
    logic [1:0]  s_hold_cnt;
    logic        s_timeout;

    always #5 CLK = ~CLK;

    pipe_stage_reg #(
        .DATA_W(16), .NOP_DATA(c_nop), .CNT_W(4), .TIMEOUT(8)
    ) u_dut (
        .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
        .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA),
        .BUBBLE_CNT(BUBBLE_CNT), .HOLD_CNT(HOLD_CNT),
        .STALL_TIMEOUT(STALL_TIMEOUT)
    );

    pipe_stage_reg #(
        .DATA_W(8), .NOP_DATA(8'h00), .CNT_W(2), .TIMEOUT(3)
    ) u_sat (
        .CLK(CLK), .RST(s_rst), .STALL(s_stall), .FLUSH(s_flush),
        .IN_VALID(s_in_valid), .IN_DATA(s_in_data),
        .OUT_VALID(s_out_valid), .OUT_DATA(s_out_data),
        .BUBBLE_CNT(s_bubble_cnt), .HOLD_CNT(s_hold_cnt),
        .STALL_TIMEOUT(s_timeout)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with all-ones payload presented
        RST = 1'b0; IN_VALID = 1'b1; IN_DATA = 16'hFFFF; STALL = 2'b00;
        step(2);
        chk("rst_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_data", 32'(OUT_DATA), 32'(c_nop));
        chk("rst_bubble", 32'(BUBBLE_CNT), 32'd0);
        chk("rst_hold", 32'(HOLD_CNT), 32'd0);
        chk("rst_timeout", 32'(STALL_TIMEOUT), 32'd0);

        // Streaming
        RST = 1'b1;
        IN_DATA = 16'd1; step(1);
        chk("stream1_data", 32'(OUT_DATA), 32'd1);
        chk("stream1_valid", 32'(OUT_VALID), 32'd1);
        IN_DATA = 16'd2; step(1);
        chk("stream2_data", 32'(OUT_DATA), 32'd2);
        IN_DATA = 16'd3; step(1);
        chk("stream3_data", 32'(OUT_DATA), 32'd3);
        chk("stream_bubble", 32'(BUBBLE_CNT), 32'd0);

        // Load with IN_VALID=0 still captures data
        IN_VALID = 1'b0; IN_DATA = 16'h0007; step(1);
        chk("inv_data", 32'(OUT_DATA), 32'h7);
        chk("inv_valid", 32'(OUT_VALID), 32'd0);

        // Bubbles
        IN_VALID = 1'b1; IN_DATA = 16'h00A5; step(1);
        chk("bub_load", 32'(OUT_DATA), 32'hA5);
        STALL = 2'b01; IN_DATA = 16'h1111; step(3);
        chk("bub_valid", 32'(OUT_VALID), 32'd0);
        chk("bub_data", 32'(OUT_DATA), 32'(c_nop));
        chk("bub_cnt", 32'(BUBBLE_CNT), 32'd3);
        chk("bub_hold", 32'(HOLD_CNT), 32'd0);

        // STALL=2'b10 loads and counts nothing
        STALL = 2'b10; IN_DATA = 16'h0033; step(1);
        chk("s10_data", 32'(OUT_DATA), 32'h33);
        chk("s10_bubble", 32'(BUBBLE_CNT), 32'd3);

        // Flush under bubble condition does not count a bubble
        STALL = 2'b01; FLUSH = 1'b1; step(1);
        chk("fb_bubble", 32'(BUBBLE_CNT), 32'd3);
        chk("fb_data", 32'(OUT_DATA), 32'(c_nop));
        chk("fb_valid", 32'(OUT_VALID), 32'd0);

        // Hold then flush
        FLUSH = 1'b0; STALL = 2'b00; IN_DATA = 16'h005A; step(1);
        STALL = 2'b11; IN_DATA = 16'h0099; step(4);
        chk("hold_data", 32'(OUT_DATA), 32'h5A);
        chk("hold_valid", 32'(OUT_VALID), 32'd1);
        chk("hold_cnt", 32'(HOLD_CNT), 32'd4);
        chk("hold_timeout", 32'(STALL_TIMEOUT), 32'd0);
        FLUSH = 1'b1; step(1);
        chk("hf_valid", 32'(OUT_VALID), 32'd0);
        chk("hf_data", 32'(OUT_DATA), 32'(c_nop));
        chk("hf_hold", 32'(HOLD_CNT), 32'd0);
        chk("hf_bubble", 32'(BUBBLE_CNT), 32'd3);

        // Timeout after 8 consecutive holds, saturation at 15
        FLUSH = 1'b0; STALL = 2'b11; step(7);
        chk("to_hold7", 32'(HOLD_CNT), 32'd7);
        chk("to_pre", 32'(STALL_TIMEOUT), 32'd0);
        step(1);
        chk("to_hold8", 32'(HOLD_CNT), 32'd8);
        chk("to_rise", 32'(STALL_TIMEOUT), 32'd1);
        step(12);
        chk("to_sat", 32'(HOLD_CNT), 32'd15);
        chk("to_sticky_hold", 32'(STALL_TIMEOUT), 32'd1);
        STALL = 2'b00; step(1);
        chk("to_after_load", 32'(STALL_TIMEOUT), 32'd1);
        chk("to_hold_clr", 32'(HOLD_CNT), 32'd0);
        FLUSH = 1'b1; step(1);
        chk("to_after_flush", 32'(STALL_TIMEOUT), 32'd1);
        RST = 1'b0; step(1);
        chk("to_after_rst", 32'(STALL_TIMEOUT), 32'd0);
        chk("rst2_bubble", 32'(BUBBLE_CNT), 32'd0);
        RST = 1'b1; FLUSH = 1'b0;

        // Saturation on the 2-bit counter, then reset priority
        s_rst = 1'b0; step(1);
        s_rst = 1'b1; s_stall = 2'b01; step(3);
        chk("sat_bub3", 32'(s_bubble_cnt), 32'd3);
        step(2);
        chk("sat_bub5", 32'(s_bubble_cnt), 32'd3);
        s_stall = 2'b00; s_in_valid = 1'b1; s_in_data = 8'h12; step(1);
        chk("sat_load", 32'(s_out_data), 32'h12);
        s_rst = 1'b0; s_flush = 1'b1; s_stall = 2'b01; step(1);
        chk("rp_bubble", 32'(s_bubble_cnt), 32'd0);
        chk("rp_valid", 32'(s_out_valid), 32'd0);
        chk("rp_data", 32'(s_out_data), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the five-stage MIPS core.
- Successor to the fixed per-stage registers: generic payload width, explicit valid bit, flush input, bubble and hold statistics, and a stall-timeout watchdog.
- Instantiated between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Stage payload fields are concatenated into DATA by the instantiating stage.

Parameters:
- DATA_W, 128, payload width in bits (>=1).
- NOP_DATA, 0 (DATA_W bits), payload value loaded on reset, flush or bubble.
- CNT_W, 16, width of bubble and hold statistics counters (>=2).
- TIMEOUT, 1024, consecutive hold cycles after which STALL_TIMEOUT asserts (1..2^CNT_W-1).

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  synchronous reset, active-low.
- STALL  in  2  bit0=1: upstream side of this register stopped; bit1=1: downstream side stopped.
- FLUSH  in  1  discard current contents and load a bubble.
- IN_VALID  in  1  upstream payload valid.
- IN_DATA  in  DATA_W  upstream payload.
- OUT_VALID  out  1  registered valid.
- OUT_DATA  out  DATA_W  registered payload.
- BUBBLE_CNT  out  CNT_W  count of bubbles inserted by stall rule, saturating.
- HOLD_CNT  out  CNT_W  current consecutive hold-cycle count, saturating.
- STALL_TIMEOUT  out  1  sticky: HOLD_CNT reached TIMEOUT.

Behaviour:
- All outputs registered; no combinational path from inputs to outputs.
- Per-edge action, in strict priority order:
  1. RST=0: OUT_VALID=0, OUT_DATA=NOP_DATA, BUBBLE_CNT=0, HOLD_CNT=0, STALL_TIMEOUT=0.
  2. FLUSH=1, any STALL: OUT_VALID=0, OUT_DATA=NOP_DATA, HOLD_CNT=0. BUBBLE_CNT unchanged. STALL_TIMEOUT unchanged.
  3. STALL[0]=0 (load): OUT_VALID=IN_VALID, OUT_DATA=IN_DATA, HOLD_CNT=0.
  4. STALL[0]=1, STALL[1]=0 (bubble): OUT_VALID=0, OUT_DATA=NOP_DATA, HOLD_CNT=0, BUBBLE_CNT+1 saturating at all-ones.
  5. STALL[0]=1, STALL[1]=1 (hold): OUT_VALID and OUT_DATA retained, HOLD_CNT+1 saturating at all-ones.
- Load with IN_VALID=0 is legal: OUT_DATA still takes IN_DATA, OUT_VALID=0.
- STALL_TIMEOUT:
  - Set on the edge where HOLD_CNT becomes equal to TIMEOUT.
  - Then stays 1 until reset; FLUSH does not clear it.
- Latency one cycle IN->OUT.
- Back-to-back loads give full throughput.
- Reset mid-hold or mid-stall overrides everything on that edge.
- The following cases count nothing: STALL=2'b10 (load wins); FLUSH during bubble conditions (no BUBBLE_CNT increment).

Test Plan:
- Reset: RST=0 for 2 cycles with IN_DATA=0xFFFF..., STALL=0 -> OUT_VALID=0, OUT_DATA=NOP_DATA, all counters 0, STALL_TIMEOUT=0.
- Streaming: STALL=0, IN_VALID=1, IN_DATA=1,2,3 on successive cycles -> OUT_DATA=1,2,3 one cycle later each, OUT_VALID=1, BUBBLE_CNT=0.
- Bubble: load 0xA5, then STALL=2'b01 for 3 cycles -> OUT_VALID=0, OUT_DATA=NOP_DATA, BUBBLE_CNT=3, HOLD_CNT=0.
- Hold plus flush:
  - Load 0x5A, then STALL=2'b11 for 4 cycles -> OUT_DATA=0x5A, OUT_VALID=1, HOLD_CNT=4.
  - Then FLUSH=1 with STALL=2'b11 -> OUT_VALID=0, OUT_DATA=NOP_DATA, HOLD_CNT=0, BUBBLE_CNT unchanged.
- Timeout (TIMEOUT=8, CNT_W=4): STALL=2'b11 for 20 cycles -> STALL_TIMEOUT rises on the 8th hold edge, HOLD_CNT saturates at 15, STALL_TIMEOUT stays 1 after STALL=0 and after FLUSH; clears only on RST=0.
- Saturation and reset priority (CNT_W=2):
  - 5 bubble cycles -> BUBBLE_CNT=3.
  - RST=0 asserted together with FLUSH=1 and STALL=2'b01 -> BUBBLE_CNT=0, OUT_VALID=0.
